// File: rtl/tug_of_war_field_pkg.sv
// Shared types and constants for the tug-of-war playfield and its CPU opponent LFSR.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    L_WON = 2'd1,
    R_WON = 2'd2
  } tow_state_e;

  localparam int               LFSR_W    = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;
  // Feedback taps for x^10 + x^7 + 1 (register bits 9 and 6).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'h240;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tug_of_war_field_if.sv
// Player/score-side signal bundle for the tug-of-war playfield.
interface tug_of_war_field_if #(
  parameter int N_LEDS = 9
) ();
  logic              l_press;
  logic              r_press;
  logic              reset_round;
  logic [9:0]        cpu_speed;
  logic [N_LEDS-1:0] leds;
  logic              l_win;
  logic              r_win;

  modport master (
    output l_press, r_press, reset_round, cpu_speed,
    input  leds, l_win, r_win
  );

  modport slave (
    input  l_press, r_press, reset_round, cpu_speed,
    output leds, l_win, r_win
  );
endinterface

// File: rtl/tug_of_war_field_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR that paces the CPU opponent's pushes.
module lfsr10
  import tow_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] out
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: turns button edges into light moves and holds a round win until reset_round.
// Build option TOW_CPU_OPPONENT_EN replaces the right player with an LFSR-paced CPU.
module tug_of_war_field
  import tow_pkg::*;
#(
  parameter int N_LEDS = 9
) (
  input logic               clk,
  input logic               reset,
  tug_of_war_field_if.slave bus
);

  localparam int             PW    = $clog2(N_LEDS);
  localparam logic [PW-1:0]  POS_C = PW'((N_LEDS - 1) / 2);
  localparam logic [PW-1:0]  POS_L = PW'(N_LEDS - 1);

  tow_state_e    state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          l_prev_q, l_prev_d;
  logic          r_prev_q, r_prev_d;
  logic          l_edge;
  logic          r_edge;

  assign l_edge = bus.l_press & ~l_prev_q;

`ifdef TOW_CPU_OPPONENT_EN
  logic [LFSR_W-1:0] lfsr;
  logic              unused_r_side;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign r_edge        = (lfsr < bus.cpu_speed);
  assign unused_r_side = r_prev_q ^ bus.r_press;
`else
  logic unused_cpu_speed;

  assign r_edge           = bus.r_press & ~r_prev_q;
  assign unused_cpu_speed = ^bus.cpu_speed;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    l_prev_d = bus.l_press;
    r_prev_d = bus.r_press;

    if (bus.reset_round) begin
      state_d = PLAY;
      pos_d   = POS_C;
    end else if (state_q == PLAY) begin
      // Simultaneous pushes cancel, so only a lone edge moves the light.
      if (l_edge && !r_edge) begin
        if (pos_q == POS_L) state_d = L_WON;
        else                pos_d   = pos_q + PW'(1);
      end else if (r_edge && !l_edge) begin
        if (pos_q == '0) state_d = R_WON;
        else             pos_d   = pos_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PLAY;
      pos_q    <= POS_C;
      l_prev_q <= 1'b0;
      r_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      l_prev_q <= l_prev_d;
      r_prev_q <= r_prev_d;
    end
  end

  always_comb begin
    bus.leds = '0;
    if (state_q == PLAY) bus.leds[pos_q] = 1'b1;
    bus.l_win = (state_q == L_WON);
    bus.r_win = (state_q == R_WON);
  end

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed self-checking bench for tug_of_war_field with N_LEDS = 9 (centre index 4).
module tb_tug_of_war_field;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  tug_of_war_field_if #(.N_LEDS(9)) bus ();

  tug_of_war_field #(.N_LEDS(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic l_pulse();
    bus.l_press = 1'b1;
    tick();
    bus.l_press = 1'b0;
  endtask

  task automatic r_pulse();
    bus.r_press = 1'b1;
    tick();
    bus.r_press = 1'b0;
  endtask

  task automatic idle2();
    tick();
    tick();
  endtask

  task automatic round_restart();
    bus.reset_round = 1'b1;
    tick();
    bus.reset_round = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] exp_leds;
    n_checks        = 0;
    n_fails         = 0;
    reset           = 1'b0;
    bus.l_press     = 1'b0;
    bus.r_press     = 1'b0;
    bus.reset_round = 1'b0;
    bus.cpu_speed   = 10'd0;

    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_leds", 32'(bus.leds), 32'h010);
    chk("reset_lwin", 32'(bus.l_win), 32'h0);
    chk("reset_rwin", 32'(bus.r_win), 32'h0);

    exp_leds = 9'h010;
    for (int i = 0; i < 4; i++) begin
      l_pulse();
      exp_leds = exp_leds << 1;
      chk($sformatf("lmove%0d", i + 1), 32'(bus.leds), 32'(exp_leds));
      idle2();
    end
    l_pulse();
    chk("lwin_flag", 32'(bus.l_win), 32'h1);
    chk("lwin_leds", 32'(bus.leds), 32'h0);
    chk("lwin_rwin", 32'(bus.r_win), 32'h0);
    l_pulse();
    idle2();
    chk("lwin_hold", 32'(bus.l_win), 32'h1);
    chk("lwin_hold_leds", 32'(bus.leds), 32'h0);
    round_restart();
    chk("restart_leds", 32'(bus.leds), 32'h010);
    chk("restart_lwin", 32'(bus.l_win), 32'h0);

    bus.l_press = 1'b1;
    repeat (10) tick();
    bus.l_press = 1'b0;
    chk("held_one_move", 32'(bus.leds), 32'h020);
    tick();

    bus.l_press     = 1'b1;
    bus.reset_round = 1'b1;
    tick();
    bus.l_press     = 1'b0;
    bus.reset_round = 1'b0;
    chk("rr_ignores_edge", 32'(bus.leds), 32'h010);
    tick();

`ifndef TOW_CPU_OPPONENT_EN
    bus.l_press = 1'b1;
    bus.r_press = 1'b1;
    tick();
    bus.l_press = 1'b0;
    bus.r_press = 1'b0;
    chk("both_cancel", 32'(bus.leds), 32'h010);
    tick();

    exp_leds = 9'h010;
    for (int i = 0; i < 4; i++) begin
      r_pulse();
      exp_leds = exp_leds >> 1;
      chk($sformatf("rmove%0d", i + 1), 32'(bus.leds), 32'(exp_leds));
      tick();
    end
    r_pulse();
    chk("rwin_flag", 32'(bus.r_win), 32'h1);
    chk("rwin_leds", 32'(bus.leds), 32'h0);
    round_restart();
    chk("restart2_rwin", 32'(bus.r_win), 32'h0);
`endif

    for (int i = 0; i < 3; i++) begin
      l_pulse();
      tick();
    end
    chk("pre_reset_pos7", 32'(bus.leds), 32'h080);
    reset = 1'b0;
    #2;
    chk("async_reset_leds", 32'(bus.leds), 32'h010);
    chk("async_reset_lwin", 32'(bus.l_win), 32'h0);
    tick();
    reset = 1'b1;
    tick();

`ifdef TOW_CPU_OPPONENT_EN
    bus.cpu_speed = 10'd0;
    round_restart();
    for (int i = 0; i < 20; i++) begin
      bus.r_press = ~bus.r_press;
      tick();
      chk($sformatf("cpu0_hold%0d", i), 32'(bus.leds), 32'h010);
    end
    bus.r_press   = 1'b0;
    bus.cpu_speed = 10'd1023;
    round_restart();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.r_win) break;
    end
    chk("cpu_max_rwin", 32'(bus.r_win), 32'h1);
    bus.cpu_speed = 10'd0;
    round_restart();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
